// File: rtl/key_event_gen_pkg.sv
// Shared types and elaboration helpers for the key event generator.
// Channel state encoding plus ms-prescaler and counter-width functions.
package key_event_pkg;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        PRESSED   = 2'd1,
        LONG_DONE = 2'd2,
        LOCKED    = 2'd3
    } chan_state_e;

    function automatic int ms_div(input int clk_hz);
        return (clk_hz / 1000 < 1) ? 1 : clk_hz / 1000;
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// Button-side bundle: raw keys in, debounced levels and one-hot events out.
// The slave modport is the generator; the master modport is the consumer/stimulus side.
interface key_event_gen_if #(
    parameter int N_KEYS = 5
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_pulse;
    logic [N_KEYS-1:0] key_long;
    logic              pend;

    modport master (output key_raw, input key_level, key_pulse, key_long, pend);
    modport slave  (input key_raw, output key_level, key_pulse, key_long, pend);
endinterface

// File: rtl/key_event_gen_channel.sv
// One key: 2-flop synchronizer, tick-based debounce, long-press timer and channel FSM.
// press_set/long_set are combinational strobes valid in the cycle before the state update.
module key_channel
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_MS  = 20,
    parameter int LONGPRESS_MS = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_raw,
    output logic key_level,
    output logic press_set,
    output logic long_set
);
    localparam int DB_W = cnt_w(DEBOUNCE_MS);
    localparam int LP_W = cnt_w(LONGPRESS_MS);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_MS);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONGPRESS_MS);

    localparam logic [1:0] ST_ARMED     = ARMED;
    localparam logic [1:0] ST_PRESSED   = PRESSED;
    localparam logic [1:0] ST_LONG_DONE = LONG_DONE;
    localparam logic [1:0] ST_LOCKED    = LOCKED;

    logic            sync_q1;
    logic            sync_q2;
    logic            init_q;
    logic [DB_W-1:0] db_cnt;
    logic [LP_W-1:0] lp_cnt;
    logic [1:0]      state;
    logic            flip;

    // Left out of reset so a key held through reset is visible on the first cycle after it.
    always_ff @(posedge clk) begin
        sync_q1 <= key_raw;
        sync_q2 <= sync_q1;
    end

    assign flip      = !init_q && tick && (sync_q2 != key_level) && (db_cnt == DB_MAX);
    assign press_set = flip && !key_level && (state == ST_ARMED);
    assign long_set  = (state == ST_PRESSED) && (lp_cnt == LP_MAX) && !flip;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q    <= 1'b1;
            key_level <= 1'b0;
            db_cnt    <= '0;
            lp_cnt    <= '0;
            state     <= ST_ARMED;
        end else if (init_q) begin
            init_q    <= 1'b0;
            key_level <= sync_q2;
            state     <= sync_q2 ? ST_LOCKED : ST_ARMED;
        end else begin
            if (sync_q2 == key_level) begin
                db_cnt <= '0;
            end else if (flip) begin
                db_cnt    <= '0;
                key_level <= !key_level;
            end else if (tick) begin
                db_cnt <= db_cnt + 1'b1;
            end

            if (tick && lp_cnt != LP_MAX) begin
                lp_cnt <= lp_cnt + 1'b1;
            end

            case (state)
                ST_ARMED: begin
                    if (press_set) begin
                        state  <= ST_PRESSED;
                        lp_cnt <= '0;
                    end
                end
                ST_PRESSED: begin
                    if (flip) begin
                        state <= ST_ARMED;
                    end else if (long_set) begin
                        state <= ST_LONG_DONE;
                    end
                end
                ST_LONG_DONE, ST_LOCKED: begin
                    if (flip) begin
                        state <= ST_ARMED;
                    end
                end
                default: state <= ST_ARMED;
            endcase
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// Debounced key levels plus strictly one-hot press and long-press pulses for the heater FSM.
// Pulses leave one cycle after acceptance; simultaneous events queue and drain lowest index first.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int N_KEYS       = 5,
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_MS  = 20,
    parameter int LONGPRESS_MS = 2000
) (
    input logic            clk,
    input logic            rst,
    key_event_gen_if.slave bus
);
    localparam int DIV  = ms_div(CLK_HZ);
    localparam int PS_W = cnt_w(DIV - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    logic [PS_W-1:0]   ps_cnt;
    logic              tick;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] press_set;
    logic [N_KEYS-1:0] long_set;
    logic [N_KEYS-1:0] press_pend;
    logic [N_KEYS-1:0] long_pend;
    logic [N_KEYS-1:0] press_cand;
    logic [N_KEYS-1:0] long_cand;
    logic [N_KEYS-1:0] press_gnt;
    logic [N_KEYS-1:0] long_gnt;
    logic [N_KEYS-1:0] key_pulse_q;
    logic [N_KEYS-1:0] key_long_q;

    always_ff @(posedge clk) begin
        if (rst || ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    assign tick = (ps_cnt == PS_LAST);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONGPRESS_MS(LONGPRESS_MS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .key_raw  (bus.key_raw[i]),
            .key_level(key_level[i]),
            .press_set(press_set[i]),
            .long_set (long_set[i])
        );
    end

    // New strobes join the queue directly, so an uncontended press issues without a pend cycle.
    assign press_cand = press_pend | press_set;
    assign long_cand  = long_pend | long_set;
    assign press_gnt  = press_cand & (~press_cand + 1'b1);
    assign long_gnt   = long_cand & (~long_cand + 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            press_pend  <= '0;
            long_pend   <= '0;
            key_pulse_q <= '0;
            key_long_q  <= '0;
        end else if (|press_cand) begin
            key_pulse_q <= press_gnt;
            key_long_q  <= '0;
            press_pend  <= press_cand & ~press_gnt;
            long_pend   <= long_cand;
        end else begin
            key_pulse_q <= '0;
            key_long_q  <= long_gnt;
            press_pend  <= '0;
            long_pend   <= long_cand & ~long_gnt;
        end
    end

    assign bus.key_level = key_level;
    assign bus.key_pulse = key_pulse_q;
    assign bus.key_long  = key_long_q;
    assign bus.pend      = |press_pend;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with a 10-cycle ms tick, 4-tick debounce and 20-tick long press.
module tb_key_event_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_event_gen_if #(.N_KEYS(5)) bus ();

    key_event_gen #(
        .N_KEYS      (5),
        .CLK_HZ      (10_000),
        .DEBOUNCE_MS (4),
        .LONGPRESS_MS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pend_hi = 0;
    logic [4:0] level_or = '0;
    logic [4:0] pulse_q[$];
    logic [4:0] long_q[$];
    int         pulse_t[$];
    int         long_t[$];

    typedef struct {
        logic [4:0] raw;
        int         hold;
        logic [4:0] exp_level;
        int         exp_np;
        logic [4:0] exp_por;
        int         exp_nl;
        logic [4:0] exp_lor;
    } vec_t;
    vec_t vecs[6];

    task automatic chk_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        pulse_q.delete();
        pulse_t.delete();
        long_q.delete();
        long_t.delete();
        pend_hi  = 0;
        level_or = '0;
    endtask

    function automatic int pulse_or();
        logic [4:0] r = '0;
        foreach (pulse_q[i]) r |= pulse_q[i];
        return int'(r);
    endfunction

    function automatic int long_or();
        logic [4:0] r = '0;
        foreach (long_q[i]) r |= long_q[i];
        return int'(r);
    endfunction

    // Event recorder plus per-cycle one-hot / exclusivity invariants.
    always @(posedge clk) begin
        #1;
        cyc++;
        chk_eq("pulse_onehot", int'($onehot0(bus.key_pulse)), 1);
        chk_eq("long_onehot", int'($onehot0(bus.key_long)), 1);
        chk_eq("pulse_long_exclusive", int'(bus.key_pulse != 0 && bus.key_long != 0), 0);
        if (bus.key_pulse != 0) begin
            pulse_q.push_back(bus.key_pulse);
            pulse_t.push_back(cyc);
        end
        if (bus.key_long != 0) begin
            long_q.push_back(bus.key_long);
            long_t.push_back(cyc);
        end
        if (bus.pend) pend_hi++;
        level_or |= bus.key_level;
    end

    initial begin
        int t0;
        int k;

        vecs[0] = '{5'b00100, 100, 5'b00100, 1, 5'b00100, 0, 5'b00000};
        vecs[1] = '{5'b10000, 100, 5'b10000, 1, 5'b10000, 0, 5'b00000};
        vecs[2] = '{5'b01000, 300, 5'b01000, 1, 5'b01000, 1, 5'b01000};
        vecs[3] = '{5'b00110, 100, 5'b00110, 2, 5'b00110, 0, 5'b00000};
        vecs[4] = '{5'b11111, 300, 5'b11111, 5, 5'b11111, 5, 5'b11111};
        vecs[5] = '{5'b00001, 30,  5'b00000, 0, 5'b00000, 0, 5'b00000};

        rst = 1'b1;
        bus.key_raw = '0;
        wait_cyc(5);
        chk_eq("reset_level", int'(bus.key_level), 0);
        chk_eq("reset_pulse", int'(bus.key_pulse), 0);
        chk_eq("reset_long", int'(bus.key_long), 0);
        chk_eq("reset_pend", int'(bus.pend), 0);
        rst = 1'b0;
        wait_cyc(5);

        // Clean press with latency measurement
        clear_mon();
        t0 = cyc;
        bus.key_raw = 5'b00100;
        wait_cyc(100);
        chk_eq("clean_count", pulse_q.size(), 1);
        if (pulse_q.size() > 0) begin
            chk_eq("clean_value", int'(pulse_q[0]), 4);
            chk_rng("clean_latency", pulse_t[0] - t0, 43, 53);
        end
        chk_eq("clean_level", int'(bus.key_level), 4);
        bus.key_raw = '0;
        wait_cyc(80);
        chk_eq("clean_release_level", int'(bus.key_level), 0);
        chk_eq("clean_release_count", pulse_q.size(), 1);

        // Bounce shorter than the debounce window
        clear_mon();
        for (int i = 0; i < 200; i++) begin
            bus.key_raw[0] = ((i % 15) < 8);
            @(negedge clk);
        end
        bus.key_raw = '0;
        wait_cyc(80);
        chk_eq("bounce_pulses", pulse_q.size(), 0);
        chk_eq("bounce_level_seen", int'(level_or), 0);

        // Simultaneous press drains lowest index first
        clear_mon();
        t0 = cyc;
        bus.key_raw = 5'b01011;
        wait_cyc(100);
        chk_eq("simul_count", pulse_q.size(), 3);
        if (pulse_q.size() == 3) begin
            chk_eq("simul_first", int'(pulse_q[0]), 1);
            chk_eq("simul_second", int'(pulse_q[1]), 2);
            chk_eq("simul_third", int'(pulse_q[2]), 8);
            chk_eq("simul_gap1", pulse_t[1] - pulse_t[0], 1);
            chk_eq("simul_gap2", pulse_t[2] - pulse_t[1], 1);
            chk_rng("simul_latency", pulse_t[0] - t0, 43, 53);
        end
        chk_eq("simul_pend_cycles", pend_hi, 2);
        bus.key_raw = '0;
        wait_cyc(80);

        // Long press
        clear_mon();
        bus.key_raw = 5'b01000;
        wait_cyc(300);
        chk_eq("long_pulse_count", pulse_q.size(), 1);
        chk_eq("long_long_count", long_q.size(), 1);
        if (pulse_q.size() == 1 && long_q.size() == 1) begin
            chk_eq("long_pulse_value", int'(pulse_q[0]), 8);
            chk_eq("long_long_value", int'(long_q[0]), 8);
            chk_rng("long_delay", long_t[0] - pulse_t[0], 200, 210);
        end
        bus.key_raw = '0;
        wait_cyc(80);
        chk_eq("long_after_release_pulses", pulse_q.size(), 1);
        chk_eq("long_after_release_longs", long_q.size(), 1);
        chk_eq("long_release_level", int'(bus.key_level), 0);

        // Key held through reset is locked out until released
        bus.key_raw = 5'b00010;
        rst = 1'b1;
        wait_cyc(5);
        rst = 1'b0;
        clear_mon();
        wait_cyc(100);
        chk_eq("locked_pulses", pulse_q.size(), 0);
        chk_eq("locked_level", int'(bus.key_level), 2);
        bus.key_raw = '0;
        wait_cyc(80);
        chk_eq("locked_release_level", int'(bus.key_level), 0);
        chk_eq("locked_release_pulses", pulse_q.size(), 0);
        bus.key_raw = 5'b00010;
        wait_cyc(100);
        chk_eq("repress_count", pulse_q.size(), 1);
        if (pulse_q.size() > 0) chk_eq("repress_value", int'(pulse_q[0]), 2);
        bus.key_raw = '0;
        wait_cyc(80);

        // Reset while events are queued
        clear_mon();
        bus.key_raw = 5'b00111;
        k = 0;
        while (bus.key_pulse == 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk_eq("midq_first_pulse", int'(bus.key_pulse), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("midq_reset_pulse", int'(bus.key_pulse), 0);
        chk_eq("midq_reset_long", int'(bus.key_long), 0);
        chk_eq("midq_reset_pend", int'(bus.pend), 0);
        chk_eq("midq_reset_level", int'(bus.key_level), 0);
        rst = 1'b0;
        clear_mon();
        wait_cyc(150);
        chk_eq("midq_no_pulses", pulse_q.size(), 0);
        chk_eq("midq_locked_level", int'(bus.key_level), 7);
        bus.key_raw = '0;
        wait_cyc(80);
        chk_eq("midq_release_pulses", pulse_q.size(), 0);
        chk_eq("midq_release_level", int'(bus.key_level), 0);

        // Table-driven press/hold/release vectors
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            bus.key_raw = vecs[i].raw;
            wait_cyc(vecs[i].hold);
            chk_eq($sformatf("vec%0d_level", i), int'(bus.key_level), int'(vecs[i].exp_level));
            bus.key_raw = '0;
            wait_cyc(80);
            chk_eq($sformatf("vec%0d_npulse", i), pulse_q.size(), vecs[i].exp_np);
            chk_eq($sformatf("vec%0d_pulse_or", i), pulse_or(), int'(vecs[i].exp_por));
            chk_eq($sformatf("vec%0d_nlong", i), long_q.size(), vecs[i].exp_nl);
            chk_eq($sformatf("vec%0d_long_or", i), long_or(), int'(vecs[i].exp_lor));
            chk_eq($sformatf("vec%0d_release_level", i), int'(bus.key_level), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
